// File: rtl/mips_boot_pkg.sv
`default_nettype none
// mips_boot_pkg: loader state encoding and stream-format constants shared by
// imem_boot_loader and boot_word_assembler.
package mips_boot_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } boot_state_t;

   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage
`default_nettype wire

// File: rtl/boot_word_assembler.sv
`default_nettype none
// boot_word_assembler: packs accepted stream bytes MSB-first into 32-bit words
// and emits a registered one-cycle pulse when a word is complete.
module boot_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_last,
   output logic        word_valid,
   output logic [31:0] word
);
   import mips_boot_pkg::*;

   logic [BYTE_CNT_W-1:0] byte_cnt;

   // Combinational so the FSM can act on the completing byte in its own cycle.
   assign word_last = byte_valid && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         byte_cnt   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= word_last;
         if (byte_valid) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            word     <= {word[23:0], byte_data};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// imem_boot_loader: length-prefixed byte stream -> instruction-memory word writes,
// holding the core in reset until loaded. Define BOOT_CSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);
   import mips_boot_pkg::*;

   // One extra bit so a full-depth image counts up to DEPTH without wrapping.
   localparam int          CNT_W = ADDR_W + 1;
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   boot_state_t      state;
   logic [7:0]       len_hi;
   logic [LEN_W-1:0] len;
   logic [CNT_W-1:0] addr_cnt;

   logic             accept;
   logic             data_accept;
   logic             word_last;
   logic [LEN_W-1:0] len_in;
   logic             len_zero;
   logic             len_too_big;
   logic             last_word;

   assign accept      = rx_valid && rx_ready;
   assign data_accept = accept && (state == S_DATA);
   assign len_in      = {len_hi, rx_data};
   assign len_zero    = (len_in == '0);
   assign len_too_big = 32'(len_in) > DEPTH;
   assign last_word   = (32'(addr_cnt) + 32'd1) == 32'(len);

   boot_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (data_accept),
      .byte_data  (rx_data),
      .word_last  (word_last),
      .word_valid (mem_we),
      .word       (mem_wdata)
   );

`ifdef BOOT_CSUM_EN
   logic [7:0] csum;
   logic       csum_ok;

   assign csum_ok = (rx_data == csum);

   always_ff @(posedge clk) begin
      if (!reset) begin
         csum <= '0;
      end else if (accept) begin
         csum <= csum ^ rx_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_LEN_HI;
         len_hi    <= '0;
         len       <= '0;
         addr_cnt  <= '0;
         mem_addr  <= '0;
         rx_ready  <= 1'b1;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            S_LEN_HI: begin
               if (accept) begin
                  len_hi <= rx_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len <= len_in;
                  if (len_too_big) begin
                     state    <= S_ERR;
                     rx_ready <= 1'b0;
                     error    <= 1'b1;
                  end else if (len_zero) begin
`ifdef BOOT_CSUM_EN
                     state <= S_CSUM;
`else
                     state     <= S_DONE;
                     rx_ready  <= 1'b0;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (word_last) begin
                  mem_addr <= addr_cnt[ADDR_W-1:0];
                  addr_cnt <= addr_cnt + CNT_W'(1);
                  if (last_word) begin
`ifdef BOOT_CSUM_EN
                     state <= S_CSUM;
`else
                     // done is raised from S_DONE so it trails the final write pulse.
                     state    <= S_DONE;
                     rx_ready <= 1'b0;
`endif
                  end
               end
            end
`ifdef BOOT_CSUM_EN
            S_CSUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  if (csum_ok) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               rx_ready  <= 1'b0;
               done      <= 1'b1;
               cpu_reset <= 1'b0;
            end
            S_ERR: begin
               rx_ready  <= 1'b0;
               error     <= 1'b1;
               cpu_reset <= 1'b1;
            end
            default: begin
               state    <= S_ERR;
               rx_ready <= 1'b0;
               error    <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// tb_imem_boot_loader: randomized byte streams checked cycle by cycle against a
// stream-level reference model (handshake counts, word indices, completion edges).
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef BOOT_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] stim[$];

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      reset    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check("rst_rx_ready",  32'(rx_ready),  32'd1);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_done",      32'(done),      32'd0);
      check("rst_error",     32'(error),     32'd0);
   endtask

   task automatic append_csum(input bit corrupt);
      logic [7:0] x;
      x = 8'h00;
      if (CSUM) begin
         foreach (stim[i]) x ^= stim[i];
         stim.push_back(x ^ {7'd0, corrupt});
      end
   endtask

   task automatic build_stream(input int nw, input bit corrupt);
      stim.delete();
      stim.push_back(8'(nw >> 8));
      stim.push_back(8'(nw));
      if (nw > DEPTH) begin
         for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
      end else begin
         for (int i = 0; i < 4 * nw; i++) stim.push_back(8'($urandom));
         append_csum(corrupt);
      end
   endtask

   // Model: the loader consumes `stop` bytes; word k completes on byte 2+4k+3;
   // completion/fault becomes visible a fixed number of edges after the final handshake.
   task automatic run_stream(input int pct, input int abort_after);
      int n, nw, stop, acc, fin_edge, edg, idx, dly;
      bit bad, ok, hs, ready_exp, we_exp, done_exp, err_exp, finished;
      logic [7:0] x;
      n    = stim.size();
      nw   = (int'(stim[0]) << 8) | int'(stim[1]);
      bad  = nw > DEPTH;
      stop = bad ? 2 : 2 + 4 * nw + (CSUM ? 1 : 0);
      ok   = !bad;
      if (!bad && CSUM) begin
         x = 8'h00;
         for (int i = 0; i < stop - 1; i++) x ^= stim[i];
         ok = (stim[stop-1] == x);
      end
      dly      = (!bad && !CSUM && nw > 0) ? 1 : 0;
      acc      = 0;
      fin_edge = -1;
      edg      = 0;
      finished = 1'b0;
      for (int c = 0; c < 12 * n + 40 && !finished; c++) begin
         ready_exp = (acc < stop);
         check("rx_ready", 32'(rx_ready), 32'(ready_exp));
         rx_valid = (acc < n) && ($urandom_range(99) < pct);
         rx_data  = rx_valid ? stim[acc] : 8'($urandom);
         hs       = rx_valid && ready_exp;
         @(posedge clk);
         edg++;
         idx = acc;
         if (hs) begin
            acc++;
            if (acc == stop) fin_edge = edg;
         end
         @(negedge clk);
         we_exp = hs && !bad && idx >= 2 && idx < 2 + 4 * nw && ((idx - 2) % 4 == 3);
         check("mem_we", 32'(mem_we), 32'(we_exp));
         if (we_exp) begin
            check("mem_addr", 32'(mem_addr), 32'((idx - 2) / 4));
            check("mem_wdata", mem_wdata, {stim[idx-3], stim[idx-2], stim[idx-1], stim[idx]});
         end
         done_exp = ok && fin_edge >= 0 && edg >= fin_edge + dly;
         err_exp  = !ok && fin_edge >= 0 && edg >= fin_edge;
         check("done",      32'(done),      32'(done_exp));
         check("error",     32'(error),     32'(err_exp));
         check("cpu_reset", 32'(cpu_reset), 32'(!done_exp));
         if (abort_after >= 0 && acc >= abort_after) return;
         if (fin_edge >= 0 && edg >= fin_edge + 3) finished = 1'b1;
      end
      if (!finished) check("timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      // Two-word program, full rate then with gapped valid.
      do_reset();
      stim = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h08, 8'h00, 8'h05};
      append_csum(1'b0);
      run_stream(100, -1);
      do_reset();
      run_stream(50, -1);

      // Length over DEPTH, with trailing bytes that must be refused.
      do_reset();
      stim = '{8'h01, 8'h01, 8'hAA, 8'h55, 8'h12, 8'h34};
      run_stream(100, -1);

      // Empty image.
      do_reset();
      stim = '{8'h00, 8'h00};
      append_csum(1'b0);
      run_stream(100, -1);

      // Reset mid-word, then a clean single-word load.
      do_reset();
      stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_stream(100, 4);
      do_reset();
      run_stream(100, -1);

      // Checksum good and corrupted (plain single-word load without the option).
      do_reset();
      stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      append_csum(1'b0);
      run_stream(100, -1);
      do_reset();
      stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      append_csum(1'b1);
      run_stream(70, -1);

      // Full-depth image: the last address is DEPTH-1 and must not wrap.
      do_reset();
      build_stream(DEPTH, 1'b0);
      run_stream(100, -1);

      // Randomized lengths, contents, valid density and checksum corruption.
      for (int t = 0; t < 24; t++) begin
         int kind, nw;
         kind = int'($urandom_range(9));
         if (kind == 0)      nw = DEPTH + 1 + int'($urandom_range(200));
         else if (kind == 1) nw = 0;
         else                nw = int'($urandom_range(12, 1));
         do_reset();
         build_stream(nw, $urandom_range(3) == 0);
         run_stream(int'($urandom_range(100, 30)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
